// File: rtl/apb_pwm_slave.sv
// apb_pwm_slave: one-wait-state APB3 responder hosting a prescaled 8-channel PWM timer with wrap IRQ.
// Define APB_PWM_SLVERR_EN to answer undecoded accesses with PSLVERROR=1.
module apb_pwm_slave (
  input  logic        io_systemClk,
  input  logic        io_systemReset,
  input  logic [15:0] io_apbSlave_0_PADDR,
  input  logic        io_apbSlave_0_PSEL,
  input  logic        io_apbSlave_0_PENABLE,
  input  logic        io_apbSlave_0_PWRITE,
  input  logic [31:0] io_apbSlave_0_PWDATA,
  output logic [31:0] io_apbSlave_0_PRDATA,
  output logic        io_apbSlave_0_PREADY,
  output logic        io_apbSlave_0_PSLVERROR,
  output logic [7:0]  o_pwm,
  output logic        o_irq
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CH_N   = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PRE_W  = 16;
  localparam int unsigned IDX_W  = 4;

  localparam logic [IDX_W-1:0] IDX_CTRL     = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_PRESCALE = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_PERIOD   = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_STATUS   = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_COUNT    = IDX_W'(4);

`ifdef APB_PWM_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx_q;
  logic             hit_q;

  logic             en;
  logic             irq_en;
  logic [PRE_W-1:0] prescale;
  logic [CNT_W-1:0] period;
  logic             wrap;
  logic [CNT_W-1:0] duty   [CH_N];
  logic [CNT_W-1:0] active [CH_N];
  logic [PRE_W-1:0] presc_cnt;
  logic [CNT_W-1:0] count;

  logic [IDX_W-1:0]  idx_c;
  logic              hit_c;
  logic [DATA_W-1:0] rdata_c;
  logic              commit_c;
  logic              tick_c;
  logic              wrap_c;
  logic              unused_bits;

  // Word index 0..4 are control registers, 8..15 are the duty slots.
  assign idx_c    = io_apbSlave_0_PADDR[5:2];
  assign hit_c    = (io_apbSlave_0_PADDR[15:6] == '0) && ((idx_c <= IDX_COUNT) || idx_c[3]);
  assign commit_c = (state == S_WAIT) && io_apbSlave_0_PSEL && io_apbSlave_0_PENABLE
                    && io_apbSlave_0_PWRITE && hit_q;
  assign tick_c   = en && (presc_cnt == prescale);
  assign wrap_c   = tick_c && (count >= period);
  assign unused_bits = ^{io_apbSlave_0_PADDR[1:0], io_apbSlave_0_PWDATA[31:16]};

  always_comb begin
    rdata_c = '0;
    if (hit_c) begin
      if (idx_c[3]) begin
        rdata_c[CNT_W-1:0] = duty[idx_c[2:0]];
      end else begin
        case (idx_c)
          IDX_CTRL:     rdata_c[1:0]       = {irq_en, en};
          IDX_PRESCALE: rdata_c[PRE_W-1:0] = prescale;
          IDX_PERIOD:   rdata_c[CNT_W-1:0] = period;
          IDX_STATUS:   rdata_c[0]         = wrap;
          IDX_COUNT:    rdata_c[CNT_W-1:0] = count;
          default:      rdata_c            = '0;
        endcase
      end
    end
  end

  // APB handshake: capture decode and read data, then present PREADY for exactly one cycle.
  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      state                   <= S_IDLE;
      idx_q                   <= '0;
      hit_q                   <= 1'b0;
      io_apbSlave_0_PREADY    <= 1'b0;
      io_apbSlave_0_PRDATA    <= '0;
      io_apbSlave_0_PSLVERROR <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io_apbSlave_0_PSEL && io_apbSlave_0_PENABLE && !io_apbSlave_0_PREADY) begin
            state                   <= S_WAIT;
            idx_q                   <= idx_c;
            hit_q                   <= hit_c;
            io_apbSlave_0_PREADY    <= 1'b1;
            io_apbSlave_0_PRDATA    <= rdata_c;
            io_apbSlave_0_PSLVERROR <= SLVERR_EN & ~hit_c;
          end
        end
        S_WAIT: begin
          state                <= S_IDLE;
          io_apbSlave_0_PREADY <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register file; a wrap on the same cycle as a W1C leaves WRAP set.
  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      en       <= 1'b0;
      irq_en   <= 1'b0;
      prescale <= '0;
      period   <= '0;
      wrap     <= 1'b0;
      for (int unsigned i = 0; i < CH_N; i++) duty[i] <= '0;
    end else begin
      if (commit_c && idx_q == IDX_CTRL) begin
        en     <= io_apbSlave_0_PWDATA[0];
        irq_en <= io_apbSlave_0_PWDATA[1];
      end
      if (commit_c && idx_q == IDX_PRESCALE) prescale <= io_apbSlave_0_PWDATA[PRE_W-1:0];
      if (commit_c && idx_q == IDX_PERIOD)   period   <= io_apbSlave_0_PWDATA[CNT_W-1:0];
      wrap <= wrap_c | (wrap & ~(commit_c && idx_q == IDX_STATUS && io_apbSlave_0_PWDATA[0]));
      for (int unsigned i = 0; i < CH_N; i++) begin
        if (commit_c && idx_q[3] && idx_q[2:0] == 3'(i)) duty[i] <= io_apbSlave_0_PWDATA[CNT_W-1:0];
      end
    end
  end

  // Timer: duties become active only at wrap (or continuously while disabled).
  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      presc_cnt <= '0;
      count     <= '0;
      o_pwm     <= '0;
      o_irq     <= 1'b0;
      for (int unsigned i = 0; i < CH_N; i++) active[i] <= '0;
    end else begin
      if (!en) begin
        presc_cnt <= '0;
        count     <= '0;
        for (int unsigned i = 0; i < CH_N; i++) active[i] <= duty[i];
      end else if (tick_c) begin
        presc_cnt <= '0;
        if (wrap_c) begin
          count <= '0;
          for (int unsigned i = 0; i < CH_N; i++) active[i] <= duty[i];
        end else begin
          count <= count + CNT_W'(1);
        end
      end else begin
        presc_cnt <= presc_cnt + PRE_W'(1);
      end
      for (int unsigned i = 0; i < CH_N; i++) o_pwm[i] <= en & (count < active[i]);
      o_irq <= wrap & irq_en;
    end
  end

endmodule

// File: tb/tb_apb_pwm_slave.sv
// tb_apb_pwm_slave: randomized APB traffic scored against a register model, plus PWM/IRQ waveform checks.
`timescale 1ns/1ps
module tb_apb_pwm_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [7:0]  pwm;
  logic        irq;

  always #5 clk = ~clk;

  apb_pwm_slave dut (
    .io_systemClk           (clk),
    .io_systemReset         (rst),
    .io_apbSlave_0_PADDR    (paddr),
    .io_apbSlave_0_PSEL     (psel),
    .io_apbSlave_0_PENABLE  (penable),
    .io_apbSlave_0_PWRITE   (pwrite),
    .io_apbSlave_0_PWDATA   (pwdata),
    .io_apbSlave_0_PRDATA   (prdata),
    .io_apbSlave_0_PREADY   (pready),
    .io_apbSlave_0_PSLVERROR(pslverr),
    .o_pwm                  (pwm),
    .o_irq                  (irq)
  );

`ifdef APB_PWM_SLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] addr;
    bit          chk_data;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   en_cyc = 0;
  bit   clr_mark [0:63];
  logic prev_rdy = 1'b0;

  // Register model
  logic [1:0]  m_ctrl;
  logic [15:0] m_pre;
  logic [7:0]  m_per;
  logic        m_wrap;
  logic [7:0]  m_duty [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit m_hit(input logic [15:0] a);
    logic [3:0] i;
    i = a[5:2];
    return (a[15:6] == 10'd0) && ((i <= 4'd4) || i[3]);
  endfunction

  function automatic logic [31:0] m_read(input logic [15:0] a);
    logic [3:0] i;
    i = a[5:2];
    if (!m_hit(a)) return 32'd0;
    if (i[3]) return {24'd0, m_duty[i[2:0]]};
    case (i)
      4'd0:    return {30'd0, m_ctrl};
      4'd1:    return {16'd0, m_pre};
      4'd2:    return {24'd0, m_per};
      4'd3:    return {31'd0, m_wrap};
      default: return 32'd0;  // COUNT is 0 whenever the model is consulted
    endcase
  endfunction

  task automatic m_write(input logic [15:0] a, input logic [31:0] d);
    logic [3:0] i;
    i = a[5:2];
    if (!m_hit(a)) return;
    if (i[3]) m_duty[i[2:0]] = d[7:0];
    else case (i)
      4'd0: m_ctrl = d[1:0];
      4'd1: m_pre  = d[15:0];
      4'd2: m_per  = d[7:0];
      4'd3: if (d[0]) m_wrap = 1'b0;
      default: ;
    endcase
  endtask

  task automatic m_reset();
    m_ctrl = '0; m_pre = '0; m_per = '0; m_wrap = 1'b0;
    for (int i = 0; i < 8; i++) m_duty[i] = '0;
  endtask

  // Scoreboard monitor: one expectation consumed per PREADY pulse.
  always @(negedge clk) begin
    if (pready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pready", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check($sformatf("pready_single@%0h", sb_e.addr), prev_rdy, 32'd0);
        check($sformatf("pslverr@%0h", sb_e.addr), pslverr, sb_e.err);
        if (sb_e.chk_data) check($sformatf("prdata@%0h", sb_e.addr), prdata, sb_e.data);
      end
    end
    prev_rdy <= pready;
  end

  // Starts and ends one cycle-tick (+1ns) after a rising edge.
  task automatic apb(input bit wr, input logic [15:0] a, input logic [31:0] d,
                     input bit chk, input logic [31:0] exp_d);
    exp_t e;
    int   n;
    e.addr     = a;
    e.err      = ERR_EN && !m_hit(a);
    e.chk_data = chk || e.err;
    e.data     = e.err ? 32'd0 : exp_d;
    sb_q.push_back(e);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (pready !== 1'b1 && n < 8);
    check($sformatf("pready_latency@%0h", a), n, 32'd1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    apb(1'b1, a, d, 1'b0, 32'd0);
    m_write(a, d);
  endtask

  task automatic rd(input logic [15:0] a);
    apb(1'b0, a, $urandom, 1'b1, m_read(a));
  endtask

  task automatic wait_until(input int c);
    int g;
    g = 0;
    while ((cyc - en_cyc) < c && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check("schedule", cyc - en_cyc, c);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pready"}, pready, 32'd0);
    check({tag, "_pslverr"}, pslverr, 32'd0);
    check({tag, "_pwm"}, pwm, 32'd0);
    check({tag, "_irq"}, irq, 32'd0);
  endtask

  // Expected waveform from timer arithmetic: count = floor(t/(pre+1)) mod (per+1), duties swap at wrap.
  task automatic pwm_check(input int ncyc, input int pre, input int per);
    logic [7:0] act_int [8];
    logic [7:0] act_prev [8];
    logic [7:0] snap [8];
    logic       w_int, w_prev, exp_i;
    logic [7:0] exp_p;
    int         cnt, len;
    len = (pre + 1) * (per + 1);
    act_int = m_duty; act_prev = m_duty; snap = m_duty;
    w_int = 1'b0; w_prev = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c > 0 && c % len == 0) begin
        act_int = snap;
        w_int   = 1'b1;
      end else if (clr_mark[c]) begin
        w_int = 1'b0;
      end
      exp_p = '0; exp_i = 1'b0;
      if (c > 0) begin
        cnt = ((c - 1) / (pre + 1)) % (per + 1);
        for (int n = 0; n < 8; n++) exp_p[n] = (cnt < int'(act_prev[n]));
        exp_i = w_prev;
      end
      check($sformatf("o_pwm_c%0d", c), pwm, exp_p);
      check($sformatf("o_irq_c%0d", c), irq, exp_i);
      if (c % len == len - 1) snap = m_duty;
      act_prev = act_int;
      w_prev   = w_int;
    end
  endtask

  logic [15:0] ra;
  logic [31:0] rdv;
  int          rr;

  initial begin
    for (int i = 0; i < 64; i++) clr_mark[i] = 1'b0;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle_outputs("reset");
    check("reset_prdata", prdata, 32'd0);

    // All registers read 0 after reset
    for (int i = 0; i < 16; i++) if (i <= 4 || i >= 8) rd(16'(i * 4));

    // Randomized register traffic with the timer held disabled
    for (int k = 0; k < 60; k++) begin
      rr = $urandom_range(0, 15);
      if (rr <= 4)       ra = 16'(rr * 4);
      else if (rr <= 12) ra = 16'(32 + (rr - 5) * 4);
      else if (rr == 13) ra = 16'(16'h14 + 4 * $urandom_range(0, 2));
      else if (rr == 14) ra = 16'(16'h40 + 4 * $urandom_range(0, 15));
      else               ra = {10'($urandom_range(1, 1023)), 6'($urandom_range(0, 63))};
      rdv = $urandom;
      if (ra == 16'h0) rdv[0] = 1'b0;
      if ($urandom_range(0, 1) == 1) wr(ra, rdv);
      else rd(ra);
    end
    for (int i = 0; i < 16; i++) if (i <= 4 || i >= 8) rd(16'(i * 4));

    // Running PWM: 8-clock period; duty change and W1C land on wrap boundaries
    wr(16'h04, 32'd1);
    wr(16'h08, 32'd3);
    wr(16'h20, 32'd2);
    wr(16'h24, 32'd0);
    wr(16'h28, 32'd200);
    wr(16'h00, 32'd3);
    en_cyc = cyc;
    fork
      pwm_check(41, 1, 3);
      begin
        wait_until(9);
        wr(16'h20, 32'd4);
        wait_until(21);
        wr(16'h0C, 32'd1);
        clr_mark[cyc - en_cyc] = 1'b1;
        wr(16'h0C, 32'd1);
        clr_mark[cyc - en_cyc] = 1'b1;
      end
    join

    wr(16'h00, 32'd0);
    m_wrap = 1'b1;
    rd(16'h0C);
    wr(16'h0C, 32'hFFFF_FFF1);
    rd(16'h0C);
    rd(16'h10);
    rd(16'h20);
    check("disabled_pwm", pwm, 32'd0);
    check("disabled_irq", irq, 32'd0);

    // Undecoded accesses, including ones aliasing CTRL in the low bits
    rd(16'h14);
    wr(16'h0100, 32'hFFFF_FFFF);
    wr(16'h0040, 32'd3);
    rd(16'h00);
    rd(16'h0108);

    // Reset during the wait state of a PERIOD write
    begin
      exp_t e;
      e.addr = 16'h08; e.err = 1'b0; e.chk_data = 1'b0; e.data = 32'd0;
      sb_q.push_back(e);
      psel = 1'b1; penable = 1'b0; paddr = 16'h08; pwrite = 1'b1; pwdata = 32'd9;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #1;
      check("midrst_wait_state", pready, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; rst = 1'b0;
      m_reset();
      check_idle_outputs("midrst");
    end
    rd(16'h08);
    wr(16'h08, 32'd5);
    rd(16'h08);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
